// File: rtl/game_pkg.sv
// Shared types and limits for the whack-a-mole game logic.
package game_pkg;

  typedef enum logic [1:0] {StIdle, StJudge, StAdd, StHeld} judge_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MAX_COMBO        = 7;
  localparam int unsigned MAX_POINTS_BONUS = 3;
  localparam int unsigned MAX_MISS         = 255;

endpackage

// File: rtl/bcd4_counter.sv
// Four-digit packed BCD up-counter with synchronous clear, sticky at 9999.
module bcd4_counter
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;
  bcd_digit_t  digit;
  logic        carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    digit   = '0;
    if (clr) begin
      count_d = '0;
    end else if (inc && count_q != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        digit = count_q[4*i +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = digit + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mole_hit_judge.sv
// Turns scanner key strobes into single presses, judges them against the lit
// mole mask and keeps the score, combo and miss tallies.
module mole_hit_judge
  import game_pkg::*;
#(
  parameter int unsigned RELEASE_TIMEOUT = 250000,
  parameter int unsigned TMR_W           = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_en,
  input  logic [15:0] mole_mask,
  input  logic        game_active,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [3:0]  hit_idx,
  output logic [15:0] clear_req,
  output logic [15:0] score_bcd,
  output logic [2:0]  combo,
  output logic [7:0]  miss_cnt,
  output logic        busy
);

  judge_state_t     state_q, state_d;
  logic [3:0]       cur_code_q, cur_code_d;
  logic [3:0]       pend_code_q, pend_code_d;
  logic             pend_valid_q, pend_valid_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       add_left_q, add_left_d;
  logic [2:0]       combo_q, combo_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic [3:0]       hit_idx_q, hit_idx_d;
  logic [15:0]      clear_q, clear_d;
  logic             hit_q, hit_d, miss_q, miss_d;
  logic             inc_q, inc_d, busy_q, busy_d;
  logic             active_q;
  logic             active_rise;
  logic             key_new;

  assign active_rise = game_active & ~active_q;
  assign key_new     = key_en && (key_code != cur_code_q);

  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    pend_code_d  = pend_code_q;
    pend_valid_d = pend_valid_q;
    timer_d      = timer_q;
    add_left_d   = add_left_q;
    combo_d      = combo_q;
    miss_cnt_d   = miss_cnt_q;
    hit_idx_d    = hit_idx_q;
    clear_d      = '0;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    inc_d        = 1'b0;

    if (!game_active) begin
      state_d      = StIdle;
      pend_valid_d = 1'b0;
      timer_d      = '0;
    end else begin
      if (active_rise) begin
        combo_d    = '0;
        miss_cnt_d = '0;
      end
      unique case (state_q)
        StIdle: begin
          if (key_en) begin
            cur_code_d = key_code;
            timer_d    = '0;
            state_d    = StJudge;
          end
        end
        StJudge: begin
          hit_idx_d = cur_code_q;
          timer_d   = '0;
          if (mole_mask[cur_code_q]) begin
            hit_d      = 1'b1;
            clear_d    = 16'd1 << cur_code_q;
            add_left_d = 3'd1 + ((combo_q > 3'(MAX_POINTS_BONUS)) ?
                                 3'(MAX_POINTS_BONUS) : combo_q);
            combo_d    = (combo_q == 3'(MAX_COMBO)) ? combo_q : combo_q + 3'd1;
            state_d    = StAdd;
          end else begin
            miss_d     = 1'b1;
            combo_d    = '0;
            miss_cnt_d = (miss_cnt_q == 8'(MAX_MISS)) ? miss_cnt_q : miss_cnt_q + 8'd1;
            state_d    = StHeld;
          end
          if (key_new) begin
            pend_valid_d = 1'b1;
            pend_code_d  = key_code;
          end
        end
        StAdd: begin
          inc_d   = 1'b1;
          timer_d = '0;
          if (add_left_q <= 3'd1) state_d = StHeld;
          else                    add_left_d = add_left_q - 3'd1;
          if (key_new) begin
            pend_valid_d = 1'b1;
            pend_code_d  = key_code;
          end
        end
        StHeld: begin
          if (pend_valid_q) begin
            // A press that arrived while busy is judged before anything else.
            cur_code_d   = pend_code_q;
            timer_d      = '0;
            state_d      = StJudge;
            pend_valid_d = key_en && (key_code != pend_code_q);
            if (key_en) pend_code_d = key_code;
          end else if (key_new) begin
            cur_code_d = key_code;
            timer_d    = '0;
            state_d    = StJudge;
          end else if (key_en) begin
            timer_d = '0;
          end else if (timer_q == TMR_W'(RELEASE_TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = StIdle;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StJudge) || (state_d == StAdd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_code_q   <= '0;
      pend_code_q  <= '0;
      pend_valid_q <= 1'b0;
      timer_q      <= '0;
      add_left_q   <= '0;
      combo_q      <= '0;
      miss_cnt_q   <= '0;
      hit_idx_q    <= '0;
      clear_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      inc_q        <= 1'b0;
      busy_q       <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      pend_code_q  <= pend_code_d;
      pend_valid_q <= pend_valid_d;
      timer_q      <= timer_d;
      add_left_q   <= add_left_d;
      combo_q      <= combo_d;
      miss_cnt_q   <= miss_cnt_d;
      hit_idx_q    <= hit_idx_d;
      clear_q      <= clear_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      inc_q        <= inc_d;
      busy_q       <= busy_d;
      active_q     <= game_active;
    end
  end

  // Increment is registered so each point lands one edge after its ADD cycle.
  bcd4_counter u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (active_rise),
    .inc   (inc_q),
    .count (score_bcd)
  );

  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign hit_idx    = hit_idx_q;
  assign clear_req  = clear_q;
  assign combo      = combo_q;
  assign miss_cnt   = miss_cnt_q;
  assign busy       = busy_q;

endmodule

// File: doc/mole_hit_judge.md
# mole_hit_judge

Downstream consumer of the keypad scanner. Converts the scanner's repeating key code/enable stream into single press events, judges each press against the currently lit mole mask, and keeps the game tallies: BCD score, combo level and miss count. It tells the mole generator which hole to clear on a hit.

## Interface
Parameters:
- RELEASE_TIMEOUT, 250000: cycles without a matching key_en before the held key counts as released. Must exceed one full 4-row scan period (200000 cycles).
- TMR_W, 18: width of the release timer.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- key_code  in  4  scanner key code; value = hole index 0..15
- key_en  in  1  one-cycle strobe, key_code valid; repeats roughly every scan period while a key is held
- mole_mask  in  16  bit i high = mole lit in hole i
- game_active  in  1  level; high while a round runs
- hit_pulse  out  1  one-cycle pulse, press landed on a lit mole
- miss_pulse  out  1  one-cycle pulse, press landed on an empty hole
- hit_idx  out  4  hole index of the last judged press; held between presses
- clear_req  out  16  one-hot hole to extinguish; pulses together with hit_pulse, otherwise 0
- score_bcd  out  16  4-digit packed BCD score, 0000..9999
- combo  out  3  consecutive-hit level, 0..7
- miss_cnt  out  8  binary miss count, saturating at 255
- busy  out  1  high in JUDGE or ADD

## Operation
- States: IDLE, JUDGE, ADD, HELD.
- IDLE:
  - key_en=1 and game_active=1: latch key_code into cur_code, then go to JUDGE.
- JUDGE (1 cycle): sample mole_mask[cur_code].
  - Hit: register hit_pulse=1 and clear_req=1<<cur_code. Set points = 1 + min(combo,3). Increment combo, saturating at 7. Go to ADD.
  - Miss: register miss_pulse=1. Set combo=0. Increment miss_cnt, saturating at 255. Go to HELD.
  - Both cases: hit_idx=cur_code.
- ADD: points is 1..4, using the pre-increment combo.
  - Adds 1 to score_bcd per cycle for points cycles, then goes to HELD.
  - At 9999 the score stops incrementing, but all points cycles are still spent.
- HELD: release timer counts up each cycle.
  - key_en with code == cur_code: timer=0, no event (auto-repeat suppression).
  - key_en with a different code: new press. Latch the code, timer=0, go to JUDGE.
  - Timer reaches RELEASE_TIMEOUT-1: go to IDLE.
- key_en during JUDGE or ADD:
  - Code differs from cur_code: store it in a 1-entry pending register. A later differing code overwrites it.
  - Code equals cur_code: resets the timer only.
  - On entering HELD with pending valid: consume pending, as in the HELD new-press case, in the first HELD cycle.
- game_active low: force IDLE, clear pending and timer, ignore key_en. Tallies hold their values.
- game_active rising edge (registered 0→1): score_bcd, combo and miss_cnt all go to 0 in that cycle.
- BCD increment: digit 9 wraps to 0 with carry into the next digit. 9999 is sticky.

## Timing
- Reset: all outputs 0, state IDLE, pending invalid, timer 0.
- rst asserted mid-round (any state, including mid-ADD): everything returns to reset values on the next edge.
- Press latency: key_en sampled at edge N → JUDGE during cycle N+1 → hit/miss pulse high during cycle N+2 only.
- Tallies:
  - combo and miss_cnt update at the same edge the pulse appears.
  - Score: the k-th point becomes visible at edge N+2+k.
- hit_pulse and miss_pulse are mutually exclusive. clear_req is nonzero only while hit_pulse=1.
- key_en and timer expiry in the same HELD cycle: key_en wins (timer resets, or new press).
- Mask sampling: mole_mask is sampled only in JUDGE. A mole that drops in the same cycle counts as a miss.

## Structure
- Shared package (game_pkg):
  - judge state enum
  - BCD digit typedef (4 bits)
  - MAX_COMBO=7, MAX_POINTS_BONUS=3, MAX_MISS=255
- Sub-module bcd4_counter:
  - Synchronous clr and inc inputs, 16-bit packed output, saturating at 9999.
  - Reused by the round timer display.
- Judge FSM, timer, pending register and tallies stay in mole_hit_judge.

## Test plan
- Single hit, combo 0: mole_mask=0x0010, key_en with code 4 → hit_pulse at N+2, clear_req=0x0010, combo=1, score 0001.
- Held key: code 4 repeated every 200000 cycles for 1 ms → exactly one hit.
  - Stop repeats → IDLE after 250000 idle cycles.
  - Same key again → second event.
- Combo scoring: 5 consecutive hits on lit holes → score 0001+0002+0003+0004+0004 = 0014, combo=5.
  - One miss → combo=0, miss_cnt=1, score unchanged.
- Saturation:
  - Preload to 9998 via hits, then a 4-point hit → 9999 and stays.
  - 256 misses → miss_cnt=255.
- Pending press: code 4 (hit) during ADD, then code 7 on an empty hole → miss_pulse in the first HELD cycle after ADD plus 2.
- Game control:
  - game_active low → key_en ignored, no pulses.
  - 0→1 edge → tallies 0.
  - rst mid-ADD → all outputs 0 the next cycle.
